// File: rtl/inter_test_pkg.sv
// Shared constants, coefficient function and FSM state type for the inter_test
// matrix-vector block.
package inter_test_pkg;

    localparam int unsigned DIM = 4;

    typedef enum logic {LOAD, COMPUTE} state_e;

    function automatic int unsigned coef(int unsigned r, int unsigned c);
        return r + c + 1;
    endfunction

endpackage

// File: rtl/inter_mv_core.sv
// 4x4 constant-matrix x vector core: loads DIM words over a valid/ready
// channel, then emits one row dot-product per cycle.
module inter_mv_core
    import inter_test_pkg::*;
#(
    parameter int unsigned num_bits = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s1i_valid,
    input  logic [num_bits-1:0] s1i_data,
    output logic                s1i_rdy,
    output logic [num_bits-1:0] result
);

    state_e              state_q, state_d;
    logic [1:0]          idx_q;
    logic [1:0]          row_q;
    logic [num_bits-1:0] v_q [DIM];
    logic [num_bits-1:0] result_q;
    logic [num_bits-1:0] prod [DIM];
    logic [num_bits-1:0] sum_lo, sum_hi, dot;
    logic                xfer;

    assign xfer = s1i_valid && s1i_rdy;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            LOAD:    if (xfer && idx_q == 2'(DIM - 1)) state_d = COMPUTE;
            COMPUTE: if (row_q == 2'(DIM - 1)) state_d = LOAD;
            default: state_d = LOAD;
        endcase
    end

    always_comb begin
        s1i_rdy = (state_q == LOAD);
    end

    // Products and sums truncate to num_bits, giving modulo-2^num_bits results.
    always_comb begin
        for (int c = 0; c < DIM; c++) begin
            prod[c] = v_q[c] * num_bits'(coef(32'(row_q), c));
        end
        sum_lo = prod[0] + prod[1];
        sum_hi = prod[2] + prod[3];
        dot    = sum_lo + sum_hi;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q    <= 2'd0;
            row_q    <= 2'd0;
            result_q <= '0;
            for (int c = 0; c < DIM; c++) begin
                v_q[c] <= '0;
            end
        end else if (state_q == LOAD) begin
            if (xfer) begin
                v_q[idx_q] <= s1i_data;
                idx_q      <= idx_q + 2'd1;
            end
            row_q <= 2'd0;
        end else begin
            result_q <= dot;
            row_q    <= row_q + 2'd1;
            idx_q    <= 2'd0;
        end
    end

    assign result = result_q;

endmodule

// File: rtl/inter_test.sv
// Top level: internal word source, free-running cycle counter and the
// matrix-vector core.
module inter_test
    import inter_test_pkg::*;
#(
    parameter int unsigned num_bits = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [num_bits-1:0] outputer,
    output logic                s1i_rdy,
    output logic [31:0]         count_out
);

    logic                s1i_valid;
    logic [num_bits-1:0] word_q;
    logic [31:0]         count_q;

    // Source is always offering a word outside reset; it only advances on transfer.
    assign s1i_valid = rst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_q  <= num_bits'(1);
            count_q <= 32'd0;
        end else begin
            count_q <= count_q + 32'd1;
            if (s1i_valid && s1i_rdy) begin
                word_q <= word_q + num_bits'(1);
            end
        end
    end

    assign count_out = count_q;

    inter_mv_core #(
        .num_bits(num_bits)
    ) u_core (
        .clk      (clk),
        .rst_n    (rst_n),
        .s1i_valid(s1i_valid),
        .s1i_data (word_q),
        .s1i_rdy  (s1i_rdy),
        .result   (outputer)
    );

endmodule

// File: tb/tb_inter_test.sv
// Self-checking bench for inter_test at num_bits = 32 and num_bits = 8.
`timescale 1ns/1ps
module tb_inter_test;

    logic        clk;
    logic        rst_n;
    logic [31:0] outputer;
    logic        s1i_rdy;
    logic [31:0] count_out;
    logic [7:0]  outputer8;
    logic        s1i_rdy8;
    logic [31:0] count_out8;

    int checks;
    int failures;
    int e;  // edges since reset release

    inter_test #(.num_bits(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .outputer (outputer),
        .s1i_rdy  (s1i_rdy),
        .count_out(count_out)
    );

    inter_test #(.num_bits(8)) dut8 (
        .clk      (clk),
        .rst_n    (rst_n),
        .outputer (outputer8),
        .s1i_rdy  (s1i_rdy8),
        .count_out(count_out8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: row result as a plain dot product of M[r][c] = r+c+1 with
    // v[c] = 4k+c+1, reduced modulo 2^bits; held between compute phases.
    function automatic longint unsigned exp_out(int edge_n, int bits);
        int p, k, r;
        longint unsigned s;
        if (edge_n <= 4) return 0;
        p = (edge_n - 1) % 8;
        k = (edge_n - 1) / 8;
        if (p < 4) begin
            k = k - 1;
            r = 3;
        end else begin
            r = p - 4;
        end
        s = 0;
        for (int c = 0; c < 4; c++) s += longint'((r + c + 1) * (4 * k + c + 1));
        return s & ((64'd1 << bits) - 64'd1);
    endfunction

    function automatic logic exp_rdy(int edge_n);
        return (edge_n % 8) < 4;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checks++;
        if (outputer !== 32'd0 || count_out !== 32'd0 || s1i_rdy !== 1'b1) begin
            failures++;
            $display("FAIL reset_state: outputer=%0d count=%0d rdy=%b, want 0 0 1",
                     outputer, count_out, s1i_rdy);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (outputer !== 32'd0 || count_out !== 32'd0 || s1i_rdy !== 1'b1 ||
            outputer8 !== 8'd0 || s1i_rdy8 !== 1'b1) begin
            failures++;
            $display("FAIL reset_hold: outputer=%0d count=%0d rdy=%b out8=%0d, want 0 0 1 0",
                     outputer, count_out, s1i_rdy, outputer8);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
    endtask

    task automatic test_pass0();
        int want [4] = '{30, 40, 50, 60};
        for (int i = 1; i <= 9; i++) begin
            step();
            checks++;
            if (count_out !== 32'(e) || s1i_rdy !== exp_rdy(e)) begin
                failures++;
                $display("FAIL pass0_ctrl edge %0d: count=%0d rdy=%b, want %0d %b",
                         e, count_out, s1i_rdy, e, exp_rdy(e));
            end
            if (e >= 5) begin
                checks++;
                if (outputer !== ((e <= 8) ? 32'(want[e - 5]) : 32'd60)) begin
                    failures++;
                    $display("FAIL pass0_out edge %0d: outputer=%0d, want %0d", e, outputer,
                             (e <= 8) ? want[e - 5] : 60);
                end
            end
        end
    endtask

    task automatic test_pass1();
        int want [4] = '{70, 96, 122, 148};
        while (e < 16) begin
            step();
            if (e >= 13) begin
                checks++;
                if (outputer !== 32'(want[e - 13])) begin
                    failures++;
                    $display("FAIL pass1_out edge %0d: outputer=%0d, want %0d",
                             e, outputer, want[e - 13]);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(1);
        while (e < 6) step();
        checks++;
        if (outputer !== 32'd40) begin
            failures++;
            $display("FAIL midrst_pre: outputer=%0d, want 40", outputer);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (outputer !== 32'd0 || count_out !== 32'd0 || s1i_rdy !== 1'b1) begin
            failures++;
            $display("FAIL midrst_async: outputer=%0d count=%0d rdy=%b, want 0 0 1",
                     outputer, count_out, s1i_rdy);
        end
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        e = 0;
        repeat (5) step();
        checks++;
        if (outputer !== 32'd30 || count_out !== 32'd5) begin
            failures++;
            $display("FAIL midrst_restart: outputer=%0d count=%0d, want 30 5",
                     outputer, count_out);
        end
    endtask

    task automatic test_steady();
        logic [31:0] prev;
        int bad;
        do_reset(1);
        prev = count_out;
        bad = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (s1i_rdy !== exp_rdy(e) || count_out !== prev + 32'd1 ||
                outputer !== 32'(exp_out(e, 32))) begin
                bad++;
                $display("FAIL steady edge %0d: rdy=%b count=%0d out=%0d, want %b %0d %0d",
                         e, s1i_rdy, count_out, outputer, exp_rdy(e), prev + 32'd1,
                         exp_out(e, 32));
            end
            prev = count_out;
        end
        checks++;
        if (bad != 0) failures++;
    endtask

    task automatic test_random_resets();
        int run_len;
        for (int t = 0; t < 6; t++) begin
            do_reset(int'($urandom_range(1, 3)));
            run_len = int'($urandom_range(1, 40));
            repeat (run_len) step();
            checks++;
            if (outputer !== 32'(exp_out(e, 32)) || outputer8 !== 8'(exp_out(e, 8)) ||
                s1i_rdy !== exp_rdy(e) || s1i_rdy8 !== exp_rdy(e) ||
                count_out !== 32'(e) || count_out8 !== 32'(e)) begin
                failures++;
                $display("FAIL random_run %0d edge %0d: out=%0d out8=%0d rdy=%b count=%0d, want %0d %0d %b %0d",
                         t, e, outputer, outputer8, s1i_rdy, count_out, exp_out(e, 32),
                         exp_out(e, 8), exp_rdy(e), e);
            end
            #($urandom_range(1, 7));
            rst_n = 1'b0;
            #1;
            checks++;
            if (outputer !== 32'd0 || outputer8 !== 8'd0 || count_out !== 32'd0 ||
                s1i_rdy !== 1'b1) begin
                failures++;
                $display("FAIL random_async %0d: out=%0d out8=%0d count=%0d rdy=%b, want 0 0 0 1",
                         t, outputer, outputer8, count_out, s1i_rdy);
            end
        end
    endtask

    task automatic test_wrap8();
        int bad;
        do_reset(2);
        bad = 0;
        while (e < 64) begin
            step();
            if (outputer8 !== 8'(exp_out(e, 8))) begin
                bad++;
                $display("FAIL wrap8_trace edge %0d: out8=%0d, want %0d",
                         e, outputer8, exp_out(e, 8));
            end
        end
        checks++;
        if (bad != 0) failures++;
        checks++;
        if (outputer8 !== 8'd164) begin
            failures++;
            $display("FAIL wrap8_row3: out8=%0d, want 164", outputer8);
        end
        checks++;
        if (outputer !== 32'd676) begin
            failures++;
            $display("FAIL wide_row3_pass7: outputer=%0d, want 676", outputer);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        e = 0;
        rst_n = 1'b0;
        test_reset();
        test_pass0();
        test_pass1();
        test_mid_reset();
        test_steady();
        test_random_resets();
        test_wrap8();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
